fadd_arbiter: RTL and testbench

//   Shares one pipelined fadd (NSTAGE=2) between NREQ requesters using round-robin arbitration.

---
 rtl/fadd_arb_pkg.sv | 26 ++
 rtl/fadd.sv | 78 +++++++
 rtl/fadd_arb_fifo.sv | 41 ++++
 rtl/fadd_arbiter.sv | 127 ++++++++++++
 tb/tb_fadd_arbiter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fadd_arb_pkg.sv
// rtl/fadd_arb_pkg.sv - shared types and helpers for the fadd arbiter
package fadd_arb_pkg;

    localparam int FP_W     = 32;
    localparam int MAX_NREQ = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int ID_W = clog2(MAX_NREQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [FP_W-1:0] y;
        logic            ovf;
    } res_t;

endpackage

// File: rtl/fadd.sv
// rtl/fadd.sv - pipelined single-precision adder (truncating, denormals flushed)
module fadd #(
    parameter int NSTAGE = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    logic [31:0] big, sml, res;
    logic [7:0]  ea, eb, diff;
    logic [23:0] ma, mb, mb_sh;
    logic [24:0] sum;
    logic [4:0]  lz;
    logic        found, res_ovf;
    logic [9:0]  exp_n;
    logic [22:0] mant;
    logic [32:0] pipe [NSTAGE];

    always_comb begin
        big   = (x1[30:0] >= x2[30:0]) ? x1 : x2;
        sml   = (x1[30:0] >= x2[30:0]) ? x2 : x1;
        ea    = big[30:23];
        eb    = sml[30:23];
        ma    = {ea != 8'd0, big[22:0]};
        mb    = {eb != 8'd0, sml[22:0]};
        diff  = ea - eb;
        mb_sh = mb >> diff;
        sum   = (big[31] == sml[31]) ? ({1'b0, ma} + {1'b0, mb_sh})
                                     : ({1'b0, ma} - {1'b0, mb_sh});
        lz    = '0;
        found = 1'b0;
        for (int k = 23; k >= 0; k--) begin
            if (!found && sum[k]) begin
                found = 1'b1;
                lz    = 5'(23 - k);
            end
        end
        if (sum[24]) begin
            exp_n = {2'b00, ea} + 10'd1;
            mant  = sum[23:1];
        end else begin
            exp_n = {2'b00, ea} - {5'b0, lz};
            mant  = 23'(sum[23:0] << lz);
        end
        res     = '0;
        res_ovf = 1'b0;
        // Inf/NaN operands collapse to a signed infinity; exp_n[9] marks underflow
        if (ea == 8'hFF) begin
            res = {big[31], 8'hFF, 23'd0};
        end else if (!found && !sum[24]) begin
            res = '0;
        end else if (!exp_n[9] && exp_n >= 10'd255) begin
            res     = {big[31], 8'hFF, 23'd0};
            res_ovf = 1'b1;
        end else if (exp_n[9] || exp_n == 10'd0) begin
            res = '0;
        end else begin
            res = {big[31], exp_n[7:0], mant};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NSTAGE; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= {res_ovf, res};
            for (int k = 1; k < NSTAGE; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign y   = pipe[NSTAGE-1][31:0];
    assign ovf = pipe[NSTAGE-1][32];

endmodule

// File: rtl/fadd_arb_fifo.sv
// rtl/fadd_arb_fifo.sv - per-requester first-word fall-through result FIFO
module fadd_arb_fifo
    import fadd_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  res_t push_data,
    input  logic pop,
    output logic valid,
    output res_t head
);

    localparam int AW = clog2(DEPTH);

    res_t        mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = (wr_ptr != rd_ptr);
    assign head  = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            assert (!(push && full));
            if (push)          wr_ptr <= wr_ptr + 1'b1;
            if (pop && valid)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fadd_arbiter.sv
// rtl/fadd_arbiter.sv - round-robin sharing of one pipelined fadd; FADD_ARB_OVF_STICKY_EN adds sticky ovf
module fadd_arbiter
    import fadd_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int RDEPTH = 4,
    parameter int FLAT   = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [32*NREQ-1:0] req_x1,
    input  logic [32*NREQ-1:0] req_x2,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [32*NREQ-1:0] resp_y,
    output logic [NREQ-1:0]   resp_ovf
`ifdef FADD_ARB_OVF_STICKY_EN
    ,
    output logic [NREQ-1:0]   ovf_sticky,
    input  logic [NREQ-1:0]   ovf_clr
`endif
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(RDEPTH) + 1;

    logic [IW-1:0]   ptr, gnt_id;
    logic            gnt_found;
    logic [NREQ-1:0] elig, pop;
    logic [CW-1:0]   credit [NREQ];
    tag_t            tag_pipe [FLAT];
    tag_t            tag_out;
    logic [31:0]     x1, x2, fy;
    logic            fovf;
    int              cand;

    always_comb begin
        for (int i = 0; i < NREQ; i++) elig[i] = req_valid[i] && (credit[i] != '0);
    end

    // Search starts one past the last grant so every eligible requester waits < NREQ cycles
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!gnt_found && elig[IW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_id    = IW'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        x1        = '0;
        x2        = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_found && gnt_id == IW'(i)) begin
                req_ready[i] = 1'b1;
                x1           = req_x1[32*i +: 32];
                x2           = req_x2[32*i +: 32];
            end
        end
    end

    fadd #(.NSTAGE(FLAT)) u_fadd (
        .clk  (clk),
        .rstn (rstn),
        .x1   (x1),
        .x2   (x2),
        .y    (fy),
        .ovf  (fovf)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr <= IW'(NREQ - 1);
            for (int i = 0; i < NREQ; i++) credit[i] <= CW'(RDEPTH);
            for (int k = 0; k < FLAT; k++) tag_pipe[k] <= '0;
        end else begin
            if (gnt_found) ptr <= gnt_id;
            for (int i = 0; i < NREQ; i++)
                credit[i] <= credit[i] - CW'(req_ready[i]) + CW'(pop[i]);
            tag_pipe[0] <= '{valid: gnt_found, id: ID_W'(gnt_id)};
            for (int k = 1; k < FLAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign tag_out = tag_pipe[FLAT-1];

    for (genvar i = 0; i < NREQ; i++) begin : g_fifo
        res_t head;

        assign pop[i] = resp_valid[i] && resp_ready[i];

        fadd_arb_fifo #(.DEPTH(RDEPTH)) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .push      (tag_out.valid && tag_out.id == ID_W'(i)),
            .push_data ('{y: fy, ovf: fovf}),
            .pop       (pop[i]),
            .valid     (resp_valid[i]),
            .head      (head)
        );

        assign resp_y[32*i +: 32] = head.y;
        assign resp_ovf[i]        = head.ovf;
    end

`ifdef FADD_ARB_OVF_STICKY_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_sticky <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (pop[i] && resp_ovf[i]) ovf_sticky[i] <= 1'b1;
                else if (ovf_clr[i])       ovf_sticky[i] <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fadd_arbiter.sv
// tb/tb_fadd_arbiter.sv - directed and random checks of fadd_arbiter against a queue model
module tb_fadd_arbiter;

    localparam int NREQ   = 2;
    localparam int RDEPTH = 4;
    localparam int FLAT   = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, resp_ovf;
    logic [63:0] req_x1, req_x2, resp_y;
`ifdef FADD_ARB_OVF_STICKY_EN
    logic [1:0]  ovf_sticky, ovf_clr, exp_sticky;
`endif

    always #5 clk = ~clk;

    fadd_arbiter #(.NREQ(NREQ), .RDEPTH(RDEPTH), .FLAT(FLAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_ovf   (resp_ovf)
`ifdef FADD_ARB_OVF_STICKY_EN
        ,
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
`endif
    );

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        int          rdy;
    } exp_t;

    exp_t        q [2][$];
    int          outstanding [2];
    int          last, cyc, n_chk, n_fail, cnt0;
    logic [31:0] op_y [2];
    logic        op_ovf [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f32(input int v);
        int m, p;
        if (v == 0) return 32'd0;
        m = (v < 0) ? -v : v;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return {v < 0, 8'(127 + p), 23'((m << (23 - p)) & 32'h7FFFFF)};
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        req_x1[32*i +: 32] = f32(a);
        req_x2[32*i +: 32] = f32(b);
        op_y[i]   = f32(a + b);
        op_ovf[i] = 1'b0;
    endtask

    function automatic int rnd_int();
        return int'($urandom_range(0, 2000)) - 1000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            outstanding[i] = 0;
        end
        last = NREQ - 1;
`ifdef FADD_ARB_OVF_STICKY_EN
        exp_sticky = '0;
`endif
    endtask

    // One cycle: inputs are already driven; check, advance the model, wait for the next negedge
    task automatic step();
        int   g, idx;
        logic ev;
        #1;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (g < 0 && req_valid[idx] && outstanding[idx] < RDEPTH) g = idx;
        end
        check("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        if (req_valid[0] && req_ready[0]) cnt0++;
`ifdef FADD_ARB_OVF_STICKY_EN
        check("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
`endif
        for (int i = 0; i < 2; i++) begin
            ev = (q[i].size() > 0) && (q[i][0].rdy <= cyc);
            check($sformatf("resp_valid%0d", i), 32'(resp_valid[i]), 32'(ev));
            if (ev) begin
                check($sformatf("resp_y%0d", i), resp_y[32*i +: 32], q[i][0].y);
                check($sformatf("resp_ovf%0d", i), 32'(resp_ovf[i]), 32'(q[i][0].ovf));
                if (resp_ready[i] && rstn) begin
`ifdef FADD_ARB_OVF_STICKY_EN
                    if (q[i][0].ovf) exp_sticky[i] = 1'b1;
                    else if (ovf_clr[i]) exp_sticky[i] = 1'b0;
`endif
                    void'(q[i].pop_front());
                    outstanding[i]--;
                end
`ifdef FADD_ARB_OVF_STICKY_EN
                else if (ovf_clr[i]) exp_sticky[i] = 1'b0;
`endif
            end
`ifdef FADD_ARB_OVF_STICKY_EN
            else if (ovf_clr[i]) exp_sticky[i] = 1'b0;
`endif
        end
        if (g >= 0 && rstn) begin
            q[g].push_back('{y: op_y[g], ovf: op_ovf[g], rdy: cyc + FLAT + 1});
            outstanding[g]++;
            last = g;
        end
        if (!rstn) model_reset();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; cnt0 = 0;
        rstn = 1'b0; req_valid = '0; resp_ready = 2'b11;
        req_x1 = '0; req_x2 = '0;
        op_y[0] = '0; op_y[1] = '0; op_ovf[0] = 1'b0; op_ovf[1] = 1'b0;
`ifdef FADD_ARB_OVF_STICKY_EN
        ovf_clr = '0;
`endif
        model_reset();
        @(negedge clk);
        step(); step();
        rstn = 1'b1;
        check("rst_resp_y", resp_y[31:0], 32'd0);
        check("rst_resp_ovf", 32'(resp_ovf), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);

        // Single op from requester 0
        while (cyc < 5) step();
        set_op(0, 1, 2);
        check("f32_1p2", op_y[0], 32'h40400000);
        req_valid = 2'b01; step();
        req_valid = 2'b00;
        repeat (5) step();

        // Both requesters streaming, responses popped immediately
        for (int n = 0; n < 8; n++) begin
            set_op(0, rnd_int(), rnd_int());
            set_op(1, 3, -1);
            req_valid = 2'b11;
            step();
        end
        req_valid = 2'b00;
        repeat (6) step();

        // Backpressure on requester 0 while requester 1 keeps flowing
        resp_ready = 2'b10; req_valid = 2'b11; cnt0 = 0;
        for (int n = 0; n < 10; n++) begin
            set_op(0, rnd_int(), rnd_int());
            set_op(1, rnd_int(), rnd_int());
            step();
        end
        check("bp_issues", 32'(cnt0), 32'd4);
        cnt0 = 0;
        resp_ready = 2'b11; step();
        resp_ready = 2'b10;
        repeat (4) step();
        check("bp_one_more", 32'(cnt0), 32'd1);
        req_valid = 2'b00; resp_ready = 2'b11;
        repeat (10) step();

        // Overflow result
        req_x1[31:0] = 32'h7F7FFFFF; req_x2[31:0] = 32'h7F7FFFFF;
        op_y[0] = 32'h7F800000; op_ovf[0] = 1'b1;
        req_valid = 2'b01; step();
        req_valid = 2'b00;
        repeat (5) step();
`ifdef FADD_ARB_OVF_STICKY_EN
        check("sticky_set", 32'(ovf_sticky), 32'd1);
        ovf_clr = 2'b01; step();
        ovf_clr = 2'b00; step();
        check("sticky_clr", 32'(ovf_sticky), 32'd0);
`endif

        // Reset with two ops in flight
        set_op(0, 5, 6);
        req_valid = 2'b01; step(); step();
        req_valid = 2'b00; rstn = 1'b0; step();
        rstn = 1'b1;
        repeat (5) step();
        resp_ready = 2'b00; req_valid = 2'b01; cnt0 = 0;
        repeat (6) step();
        check("post_rst_credits", 32'(cnt0), 32'd4);
        req_valid = 2'b00; resp_ready = 2'b11;
        repeat (6) step();

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            set_op(0, rnd_int(), rnd_int());
            set_op(1, rnd_int(), rnd_int());
            req_valid  = 2'($urandom_range(0, 3));
            resp_ready = 2'($urandom_range(0, 3));
            step();
        end
        req_valid = 2'b00; resp_ready = 2'b11;
        repeat (12) step();
        check("drained", 32'(resp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
